seq_integer_divider: RTL and testbench

Iterative signed integer divider, parametrised in width. It divides an N-bit two's-complement dividend by an N/2-bit two's-complement divisor using one restoring step per clock, and returns an N/2-bit quotient and remainder. A per-operation mode selects truncating or Euclidean results, and an error flag covers divide-by-zero and quotient overflow. It sits behind valid/ready handshakes and replaces the combinational array divider where area matters more than latency.

---
 rtl/seq_integer_divider_pkg.sv | 19 +
 rtl/seq_integer_divider_if.sv | 32 +++
 rtl/seq_integer_divider_div_step.sv | 26 ++
 rtl/seq_integer_divider.sv | 143 ++++++++++++++
 tb/tb_seq_integer_divider.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/seq_integer_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_integer_divider_pkg
// Shared definitions for the iterative signed divider: FSM state encoding and
// the per-operation result mode constants.
// -----------------------------------------------------------------------------
package seq_integer_divider_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        LOOP  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic MODE_TRUNC = 1'b0;  // C semantics: quotient rounds toward zero
    localparam logic MODE_EUCL  = 1'b1;  // remainder always in [0, |y|)

endpackage

// File: rtl/seq_integer_divider_if.sv
// -----------------------------------------------------------------------------
// seq_integer_divider_if
// Operand and result handshake bundle for seq_integer_divider.
//   in_valid/in_ready   : operand handshake (x, y, mode)
//   out_valid/out_ready : result handshake (q, r, no_idiv)
// master : producer/consumer side (drives operands, takes results)
// slave  : divider side
// -----------------------------------------------------------------------------
interface seq_integer_divider_if #(
    parameter int N = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [N-1:0]     x;
    logic signed [N/2-1:0]   y;
    logic                    mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [N/2-1:0]   q;
    logic signed [N/2-1:0]   r;
    logic                    no_idiv;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, q, r, no_idiv
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, q, r, no_idiv
    );
endinterface

// File: rtl/seq_integer_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on magnitudes.
//   i_t    : {partial remainder, next dividend bit}, N/2+1 bits
//   i_yabs : divisor magnitude, N/2 bits
//   o_qbit : quotient bit (1 when i_t >= i_yabs)
//   o_prem : new partial remainder, always < i_yabs so it fits N/2 bits
// -----------------------------------------------------------------------------
module div_step #(
    parameter int N = 16
) (
    input  logic [N/2:0]   i_t,
    input  logic [N/2-1:0] i_yabs,
    output logic           o_qbit,
    output logic [N/2-1:0] o_prem
);
    localparam int H = N / 2;

    logic [H:0] w_yext;
    logic [H:0] w_diff;

    assign w_yext = {1'b0, i_yabs};
    assign w_diff = i_t - w_yext;
    assign o_qbit = (i_t >= w_yext);
    assign o_prem = o_qbit ? w_diff[H-1:0] : i_t[H-1:0];
endmodule

// File: rtl/seq_integer_divider.sv
// -----------------------------------------------------------------------------
// seq_integer_divider
// Iterative signed divider: N-bit dividend / N/2-bit divisor, one restoring
// step per clock, truncating or Euclidean result, error flag for divide-by-zero
// and quotient overflow.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous reset, active-high
//   io_bus : operand/result handshakes (slave side of seq_integer_divider_if)
// -----------------------------------------------------------------------------
module seq_integer_divider
    import seq_integer_divider_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    seq_integer_divider_if.slave  io_bus
);
    localparam int H  = N / 2;
    localparam int CW = (H > 1) ? $clog2(H) : 1;
    localparam logic signed [H:0] ONE = 1;

    state_t         r_state, w_state_nxt;
    logic [H-1:0]   r_xhi, r_xlo, r_yabs, r_prem;
    logic           r_sx, r_sy, r_mode, r_err;
    logic [CW-1:0]  r_cnt;
    logic signed [H-1:0] r_q, r_r;
    logic           r_no_idiv, r_out_valid;

    logic [N-1:0]   w_xabs;
    logic [H-1:0]   w_yabs;
    logic           w_no_div, w_qbit, w_ovf;
    logic [H-1:0]   w_prem;
    logic signed [H:0] w_qmag, w_rmag, w_yext, w_qt, w_rt, w_qf, w_rf;

    // Quotient does not fit H signed bits when the two top bits disagree.
    function automatic logic q_out_of_range(input logic signed [H:0] v);
        return v[H] != v[H-1];
    endfunction

    // Magnitudes are treated as unsigned, so the most negative input maps correctly.
    assign w_xabs = io_bus.x[N-1] ? $unsigned(-io_bus.x) : $unsigned(io_bus.x);
    assign w_yabs = io_bus.y[H-1] ? $unsigned(-io_bus.y) : $unsigned(io_bus.y);

    // |x| >= |y|*2^H is exactly "upper half of |x| >= |y|".
    assign w_no_div = (r_yabs == '0) || (r_xhi >= r_yabs);

    div_step #(.N(N)) u_step (
        .i_t    ({r_prem, r_xlo[H-1]}),
        .i_yabs (r_yabs),
        .o_qbit (w_qbit),
        .o_prem (w_prem)
    );

    // r_xlo doubles as the quotient register: dividend bits shift out of the
    // top while quotient bits shift in at the bottom.
    assign w_qmag = $signed({1'b0, r_xlo});
    assign w_rmag = $signed({1'b0, r_prem});
    assign w_yext = $signed({1'b0, r_yabs});
    assign w_qt   = (r_sx ^ r_sy) ? -w_qmag : w_qmag;
    assign w_rt   = r_sx ? -w_rmag : w_rmag;

    always_comb begin
        w_qf = w_qt;
        w_rf = w_rt;
        if (r_mode == MODE_EUCL && w_rt < 0) begin
            w_qf = r_sy ? (w_qt + ONE) : (w_qt - ONE);
            w_rf = w_rt + w_yext;
        end
    end

    assign w_ovf = q_out_of_range(w_qf);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (io_bus.in_valid) w_state_nxt = CHECK;
            // The error path passes through FIX so results load on the same
            // register stage as the normal path (out_valid two edges after accept).
            CHECK:   w_state_nxt = w_no_div ? FIX : LOOP;
            LOOP:    if (r_cnt == '0) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    if (io_bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_no_idiv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == FIX) begin
                r_out_valid <= 1'b1;
                if (r_err || w_ovf) begin
                    r_q       <= '0;
                    r_r       <= '0;
                    r_no_idiv <= 1'b1;
                end else begin
                    r_q       <= w_qf[H-1:0];
                    r_r       <= w_rf[H-1:0];
                    r_no_idiv <= 1'b0;
                end
            end else if (r_state == DONE && io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        case (r_state)
            IDLE: if (io_bus.in_valid) begin
                r_xhi  <= w_xabs[N-1:H];
                r_xlo  <= w_xabs[H-1:0];
                r_yabs <= w_yabs;
                r_sx   <= io_bus.x[N-1];
                r_sy   <= io_bus.y[H-1];
                r_mode <= io_bus.mode;
            end
            CHECK: begin
                r_prem <= r_xhi;
                r_cnt  <= CW'(H - 1);
                r_err  <= w_no_div;
            end
            LOOP: begin
                r_prem <= w_prem;
                r_xlo  <= {r_xlo[H-2:0], w_qbit};
                r_cnt  <= r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    assign io_bus.in_ready  = (r_state == IDLE);
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.q         = r_q;
    assign io_bus.r         = r_r;
    assign io_bus.no_idiv   = r_no_idiv;
endmodule

// File: tb/tb_seq_integer_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_integer_divider
// Directed bench for seq_integer_divider with N = 16.
// -----------------------------------------------------------------------------
module tb_seq_integer_divider;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_integer_divider_if #(.N(16)) bus ();

    seq_integer_divider #(.N(16)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, wait (bounded) for out_valid; leaves out_ready low.
    task automatic do_op(input logic signed [15:0] a, input logic signed [7:0] b,
                         input logic m, output int lat,
                         output logic signed [7:0] qo, output logic signed [7:0] ro,
                         output logic eo);
        logic ok;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.x         = a;
        bus.y         = b;
        bus.mode      = m;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = 16'h5a5a;
        bus.y        = 8'h33;
        bus.mode     = ~m;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
        qo = bus.q;
        ro = bus.r;
        eo = bus.no_idiv;
    endtask

    task automatic release_op();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.x = '0; bus.y = '0; bus.mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.q !== 8'sd0 || bus.r !== 8'sd0) begin n_errors++; $display("FAIL reset_qr got q=%0d r=%0d exp 0 0", bus.q, bus.r); end
        n_checks++; if (bus.no_idiv !== 1'b0) begin n_errors++; $display("FAIL reset_no_idiv got %b exp 0", bus.no_idiv); end
    endtask

    task automatic test_trunc();
        int lat; logic signed [7:0] qo, ro; logic eo;
        do_op(16'sd100, 8'sd7, 1'b0, lat, qo, ro, eo);
        n_checks++; if (lat !== 10) begin n_errors++; $display("FAIL trunc_latency got %0d exp 10", lat); end
        n_checks++; if (qo !== 8'sd14) begin n_errors++; $display("FAIL trunc_q got %0d exp 14", qo); end
        n_checks++; if (ro !== 8'sd2) begin n_errors++; $display("FAIL trunc_r got %0d exp 2", ro); end
        n_checks++; if (eo !== 1'b0) begin n_errors++; $display("FAIL trunc_err got %b exp 0", eo); end
        release_op();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL trunc_release_ov got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL trunc_release_ir got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_signs();
        int lat; logic signed [7:0] qo, ro; logic eo;
        do_op(-16'sd100, 8'sd7, 1'b0, lat, qo, ro, eo);
        n_checks++; if (qo !== -8'sd14 || ro !== -8'sd2) begin n_errors++; $display("FAIL neg_trunc got q=%0d r=%0d exp -14 -2", qo, ro); end
        release_op();
        do_op(-16'sd100, 8'sd7, 1'b1, lat, qo, ro, eo);
        n_checks++; if (qo !== -8'sd15 || ro !== 8'sd5) begin n_errors++; $display("FAIL neg_eucl_pos_y got q=%0d r=%0d exp -15 5", qo, ro); end
        n_checks++; if (lat !== 10) begin n_errors++; $display("FAIL eucl_latency got %0d exp 10", lat); end
        release_op();
        do_op(-16'sd100, -8'sd7, 1'b1, lat, qo, ro, eo);
        n_checks++; if (qo !== 8'sd15 || ro !== 8'sd5) begin n_errors++; $display("FAIL neg_eucl_neg_y got q=%0d r=%0d exp 15 5", qo, ro); end
        release_op();
    endtask

    task automatic test_no_adjust();
        int lat; logic signed [7:0] qo, ro; logic eo;
        do_op(-16'sd21, 8'sd7, 1'b1, lat, qo, ro, eo);
        n_checks++; if (qo !== -8'sd3 || ro !== 8'sd0 || eo !== 1'b0) begin n_errors++; $display("FAIL eucl_exact got q=%0d r=%0d e=%b exp -3 0 0", qo, ro, eo); end
        release_op();
    endtask

    task automatic test_errors();
        int lat; logic signed [7:0] qo, ro; logic eo;
        do_op(16'sd100, 8'sd0, 1'b0, lat, qo, ro, eo);
        n_checks++; if (eo !== 1'b1 || qo !== 8'sd0 || ro !== 8'sd0) begin n_errors++; $display("FAIL div_zero got q=%0d r=%0d e=%b exp 0 0 1", qo, ro, eo); end
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL div_zero_latency got %0d exp 2", lat); end
        release_op();
        do_op(16'sd16384, 8'sd64, 1'b0, lat, qo, ro, eo);
        n_checks++; if (eo !== 1'b1 || qo !== 8'sd0 || ro !== 8'sd0) begin n_errors++; $display("FAIL check_ovf got q=%0d r=%0d e=%b exp 0 0 1", qo, ro, eo); end
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL check_ovf_latency got %0d exp 2", lat); end
        release_op();
        do_op(16'sd1024, 8'sd8, 1'b0, lat, qo, ro, eo);
        n_checks++; if (eo !== 1'b1 || qo !== 8'sd0 || ro !== 8'sd0) begin n_errors++; $display("FAIL fix_ovf got q=%0d r=%0d e=%b exp 0 0 1", qo, ro, eo); end
        n_checks++; if (lat !== 10) begin n_errors++; $display("FAIL fix_ovf_latency got %0d exp 10", lat); end
        release_op();
        do_op(-16'sd1024, 8'sd8, 1'b0, lat, qo, ro, eo);
        n_checks++; if (eo !== 1'b0 || qo !== -8'sd128 || ro !== 8'sd0) begin n_errors++; $display("FAIL min_quot got q=%0d r=%0d e=%b exp -128 0 0", qo, ro, eo); end
        release_op();
    endtask

    task automatic test_backpressure();
        int lat; logic signed [7:0] qo, ro; logic eo;
        int bad;
        do_op(16'sd100, 8'sd7, 1'b0, lat, qo, ro, eo);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x = 16'sd50; bus.y = 8'sd3;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.q !== 8'sd14 || bus.r !== 8'sd2 ||
                bus.no_idiv !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad); end
        bus.in_valid = 1'b0;
        release_op();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL busy_not_queued got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x = 16'sd100; bus.y = 8'sd7; bus.mode = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_in_ready got %b exp 1", bus.in_ready); end
        n_checks++; if (bus.q !== 8'sd0 || bus.no_idiv !== 1'b0) begin n_errors++; $display("FAIL midreset_outputs got q=%0d e=%b exp 0 0", bus.q, bus.no_idiv); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL midreset_out_valid got %0d cycles high exp 0", seen); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_trunc();
        test_signs();
        test_no_adjust();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
